// File: rtl/adc_sample_scheduler_pkg.sv
// Shared definitions for the ADC sample scheduler: FSM encoding, the default
// timeout and the width helper for the timeout counter.
package adc_sample_scheduler_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CONV      = 3'd1,
        S_WAIT_ADC  = 3'd2,
        S_ISSUE     = 3'd3,
        S_WAIT_PROC = 3'd4,
        S_HOLD      = 3'd5,
        S_WAIT_PER  = 3'd6
    } state_t;

    localparam int TMO_CYC_DEFAULT = 64;

    // The timeout counter is loaded with TMO_CYC-2, so clog2(TMO_CYC) bits suffice.
    function automatic int tmo_timer_w(input int cyc);
        return (cyc < 4) ? 2 : $clog2(cyc);
    endfunction

endpackage

// File: rtl/adc_sample_scheduler_timer.sv
// Loadable down-counter that stops at zero; zero is a combinational flag on the
// current count so the FSM can act in the same cycle the count runs out.
module adc_sample_scheduler_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/adc_sample_scheduler.sv
// Sequences ADC conversions at a programmed period, forwards each sample to the
// ln processor and hands its result downstream over valid/ready.
module adc_sample_scheduler
    import adc_sample_scheduler_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int PER_W   = 16,
    parameter int CNT_W   = 10,
    parameter int TMO_CYC = TMO_CYC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [PER_W-1:0]  period,
    input  logic [CNT_W-1:0]  burst_len,
    output logic              adc_convst,
    input  logic              adc_drdy,
    input  logic [DATA_W-1:0] adc_data_in,
    output logic [DATA_W-1:0] adc_data,
    output logic              valid_in,
    input  logic              proc_wr_en,
    input  logic [DATA_W-1:0] proc_result,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  sample_cnt,
    output logic              overrun,
    output logic              timeout_err
);

    localparam int              TMO_W    = tmo_timer_w(TMO_CYC);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'((TMO_CYC > 2) ? TMO_CYC - 2 : 0);

    state_t            state;
    logic [PER_W-1:0]  period_r;
    logic [CNT_W-1:0]  burst_r;
    logic              stop_pend;
    logic              ovr_seen;

    logic              per_zero;
    logic              tmo_zero;
    logic              tmo_load;
    logic              per_load;
    logic [PER_W-1:0]  per_src;
    logic [PER_W-1:0]  per_load_val;

    logic              start_ok;
    logic              accept;
    logic              burst_hit;
    logic              burst_next;
    logic              finish_wp;
    logic              rearm_wp;
    logic              rearm_hold;
    logic              in_sample;

    always_comb begin
        start_ok   = (state == S_IDLE) && start && !stop;
        accept     = (state == S_HOLD) && res_ready;
        burst_hit  = (burst_r != '0) && (sample_cnt == burst_r);
        burst_next = (burst_r != '0) && ((sample_cnt + CNT_W'(1)) == burst_r);
        finish_wp  = (state == S_WAIT_PER) && (stop_pend || burst_hit);
        rearm_wp   = (state == S_WAIT_PER) && !(stop_pend || burst_hit) && per_zero;
        // A sample that overran its slot goes straight to the next conversion.
        rearm_hold = accept && per_zero && !stop_pend && !burst_next;
        in_sample  = (state == S_WAIT_ADC) || (state == S_ISSUE) ||
                     (state == S_WAIT_PROC) || (state == S_HOLD);
    end

    // The period timer is loaded on the edge that enters CONV, so it spans
    // exactly 'period' cycles from one convst pulse to the next.
    always_comb begin
        per_load     = start_ok || rearm_wp || rearm_hold;
        per_src      = start_ok ? period : period_r;
        per_load_val = (per_src == '0) ? '0 : per_src - PER_W'(1);
        tmo_load     = (state == S_CONV) || (state == S_ISSUE);
    end

    adc_sample_scheduler_timer #(.W(PER_W)) u_period_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (per_load),
        .load_val (per_load_val),
        .zero     (per_zero)
    );

    adc_sample_scheduler_timer #(.W(TMO_W)) u_timeout_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmo_load),
        .load_val (TMO_LOAD),
        .zero     (tmo_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            period_r    <= '0;
            burst_r     <= '0;
            stop_pend   <= 1'b0;
            ovr_seen    <= 1'b0;
            adc_convst  <= 1'b0;
            adc_data    <= '0;
            valid_in    <= 1'b0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            sample_cnt  <= '0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            adc_convst  <= 1'b0;
            valid_in    <= 1'b0;
            done        <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;

            if (stop && (state != S_IDLE)) begin
                stop_pend <= 1'b1;
            end

            if (in_sample && per_zero && !ovr_seen) begin
                overrun  <= 1'b1;
                ovr_seen <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    stop_pend <= 1'b0;
                    if (start_ok) begin
                        period_r   <= period;
                        burst_r    <= burst_len;
                        sample_cnt <= '0;
                        ovr_seen   <= 1'b0;
                        adc_convst <= 1'b1;
                        busy       <= 1'b1;
                        state      <= S_CONV;
                    end
                end
                S_CONV: begin
                    state <= S_WAIT_ADC;
                end
                S_WAIT_ADC: begin
                    if (adc_drdy) begin
                        adc_data <= adc_data_in;
                        valid_in <= 1'b1;
                        state    <= S_ISSUE;
                    end else if (tmo_zero) begin
                        timeout_err <= 1'b1;
                        state       <= S_WAIT_PER;
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT_PROC;
                end
                S_WAIT_PROC: begin
                    if (proc_wr_en) begin
                        res_data  <= proc_result;
                        res_valid <= 1'b1;
                        state     <= S_HOLD;
                    end else if (tmo_zero) begin
                        timeout_err <= 1'b1;
                        state       <= S_WAIT_PER;
                    end
                end
                S_HOLD: begin
                    if (accept) begin
                        res_valid  <= 1'b0;
                        sample_cnt <= sample_cnt + CNT_W'(1);
                        if (rearm_hold) begin
                            ovr_seen   <= 1'b0;
                            adc_convst <= 1'b1;
                            state      <= S_CONV;
                        end else begin
                            state <= S_WAIT_PER;
                        end
                    end
                end
                S_WAIT_PER: begin
                    if (finish_wp) begin
                        stop_pend <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= S_IDLE;
                    end else if (rearm_wp) begin
                        ovr_seen   <= 1'b0;
                        adc_convst <= 1'b1;
                        state      <= S_CONV;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Directed bench for adc_sample_scheduler: table of full runs plus hand-written
// sequences for timeout, stop, asynchronous reset and ignored start pulses.
module tb_adc_sample_scheduler;

    localparam int DATA_W = 16;
    localparam int PER_W  = 16;
    localparam int CNT_W  = 10;
    localparam int TMO    = 64;
    localparam logic [15:0] KEY = 16'h98DC;

    logic              clk;
    logic              rst;
    logic              start;
    logic              stop;
    logic [PER_W-1:0]  period_in;
    logic [CNT_W-1:0]  burst_in;
    logic              adc_convst;
    logic              adc_drdy;
    logic [DATA_W-1:0] adc_data_in;
    logic [DATA_W-1:0] adc_data;
    logic              valid_in;
    logic              proc_wr_en;
    logic [DATA_W-1:0] proc_result;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  sample_cnt;
    logic              overrun;
    logic              timeout_err;

    adc_sample_scheduler #(
        .DATA_W(DATA_W), .PER_W(PER_W), .CNT_W(CNT_W), .TMO_CYC(TMO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .period(period_in), .burst_len(burst_in),
        .adc_convst(adc_convst), .adc_drdy(adc_drdy), .adc_data_in(adc_data_in),
        .adc_data(adc_data), .valid_in(valid_in),
        .proc_wr_en(proc_wr_en), .proc_result(proc_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy), .done(done), .sample_cnt(sample_cnt),
        .overrun(overrun), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // ---------------- environment models ----------------
    int          adc_dly = 0;
    int          adc_left = 0;
    logic [15:0] adc_next = 16'h0;
    logic [15:0] exp_adc = 16'h0;
    int          proc_dly = 1;
    int          proc_left = 0;
    int          stall_cfg = 0;
    int          stall_left = 0;

    initial begin
        adc_drdy = 1'b0;
        adc_data_in = '0;
        forever begin
            @(negedge clk);
            adc_drdy = 1'b0;
            if (adc_convst && adc_dly > 0) begin
                adc_left = adc_dly;
            end else if (adc_left > 0) begin
                adc_left--;
                if (adc_left == 0) begin
                    adc_drdy    = 1'b1;
                    adc_data_in = adc_next;
                    exp_adc     = adc_next;
                    adc_next    = adc_next + 16'h0101;
                end
            end
        end
    end

    initial begin
        proc_wr_en = 1'b0;
        proc_result = '0;
        forever begin
            @(negedge clk);
            proc_wr_en = 1'b0;
            if (valid_in) begin
                proc_left = proc_dly;
            end else if (proc_left > 0) begin
                proc_left--;
                if (proc_left == 0) begin
                    proc_wr_en  = 1'b1;
                    proc_result = exp_adc ^ KEY;
                end
            end
        end
    end

    initial begin
        res_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (valid_in) stall_left = stall_cfg;
            if (res_valid) begin
                if (stall_left > 0) begin
                    res_ready = 1'b0;
                    stall_left--;
                end else begin
                    res_ready = 1'b1;
                end
            end else begin
                res_ready = 1'b0;
            end
        end
    end

    // ---------------- monitor ----------------
    int          n_conv, n_done, n_ovr, n_tmo, n_vin;
    int          conv_cyc[$];
    int          tmo_cyc[$];
    logic        prev_rv = 1'b0;
    logic [15:0] prev_rd = '0;
    logic        acc_seen = 1'b0;

    always @(posedge clk) if (res_valid && res_ready) acc_seen = 1'b1;

    always @(negedge clk) begin
        if (rst) begin
            if (adc_convst) begin n_conv++; conv_cyc.push_back(cyc); end
            if (done) n_done++;
            if (overrun) n_ovr++;
            if (timeout_err) begin n_tmo++; tmo_cyc.push_back(cyc); end
            if (valid_in) begin
                n_vin++;
                chk("adc_data_at_valid_in", int'(adc_data), int'(exp_adc));
            end
            if (res_valid && !prev_rv) chk("res_data_capture", int'(res_data), int'(exp_adc ^ KEY));
            if (res_valid && prev_rv) chk("res_data_stable", int'(res_data), int'(prev_rd));
            if (prev_rv && !res_valid) chk("res_valid_held_until_accept", int'(acc_seen), 1);
        end
        prev_rv  = rst ? res_valid : 1'b0;
        prev_rd  = res_data;
        acc_seen = 1'b0;
    end

    task automatic clear_mon();
        n_conv = 0; n_done = 0; n_ovr = 0; n_tmo = 0; n_vin = 0;
        conv_cyc.delete();
        tmo_cyc.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (n_done == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, ".done_within_budget"}, int'(n_done != 0), 1);
    endtask

    // ---------------- table of full runs ----------------
    typedef struct {
        string       name;
        int          period;
        int          burst;
        int          adc_dly;
        int          proc_dly;
        int          stall;
        logic [15:0] adc0;
        int          e_conv;
        int          e_cnt;
        int          e_ovr;
        int          e_space;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{"burst3_p20",  20, 3, 5, 4,  0, 16'h1234, 3, 3, 0, 20};
        vecs[1] = '{"stall30_p20", 20, 1, 5, 4, 30, 16'h8000, 1, 1, 1,  0};
        vecs[2] = '{"burst4_p30",  30, 4, 3, 2,  0, 16'h0100, 4, 4, 0, 30};
        vecs[3] = '{"overrun_p5",   5, 2, 5, 4,  0, 16'hFFFE, 2, 2, 2, 12};
        vecs[4] = '{"period0",      0, 1, 1, 1,  0, 16'h0001, 1, 1, 1,  0};

        rst = 1'b0; start = 1'b0; stop = 1'b0;
        period_in = '0; burst_in = '0;
        clear_mon();

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_ctrl_outputs",
            int'({busy, done, adc_convst, valid_in, res_valid, overrun, timeout_err}), 0);
        chk("reset_sample_cnt", int'(sample_cnt), 0);
        chk("reset_data_outputs", int'({adc_data, res_data}), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            clear_mon();
            adc_dly = vecs[i].adc_dly; proc_dly = vecs[i].proc_dly;
            stall_cfg = vecs[i].stall; adc_next = vecs[i].adc0;
            period_in = PER_W'(vecs[i].period); burst_in = CNT_W'(vecs[i].burst);
            pulse_start();
            chk({vecs[i].name, ".convst_after_start"}, int'(adc_convst), 1);
            wait_done(vecs[i].name, 3000);
            repeat (3) @(negedge clk);
            chk({vecs[i].name, ".convst_count"}, n_conv, vecs[i].e_conv);
            chk({vecs[i].name, ".sample_cnt"}, int'(sample_cnt), vecs[i].e_cnt);
            chk({vecs[i].name, ".done_count"}, n_done, 1);
            chk({vecs[i].name, ".overrun_count"}, n_ovr, vecs[i].e_ovr);
            chk({vecs[i].name, ".timeout_count"}, n_tmo, 0);
            chk({vecs[i].name, ".busy_after_done"}, int'(busy), 0);
            for (int k = 1; k < conv_cyc.size(); k++)
                if (vecs[i].e_space != 0)
                    chk({vecs[i].name, ".convst_spacing"}, conv_cyc[k] - conv_cyc[k-1], vecs[i].e_space);
        end

        // ADC never answers: timeout TMO cycles after convst, next convst on the period boundary
        clear_mon();
        adc_dly = 0; period_in = 16'd100; burst_in = '0;
        pulse_start();
        for (int n = 0; n < 400 && n_tmo < 2; n++) @(negedge clk);
        chk("timeout.count", n_tmo, 2);
        if (n_tmo >= 2 && conv_cyc.size() >= 2) begin
            chk("timeout.offset0", tmo_cyc[0] - conv_cyc[0], TMO);
            chk("timeout.offset1", tmo_cyc[1] - conv_cyc[1], TMO);
            chk("timeout.convst_spacing", conv_cyc[1] - conv_cyc[0], 100);
        end
        chk("timeout.sample_cnt", int'(sample_cnt), 0);
        chk("timeout.no_valid_in", n_vin, 0);
        pulse_stop();
        wait_done("timeout_stop", 300);
        @(negedge clk);
        chk("timeout.busy_after_stop", int'(busy), 0);

        // Continuous run, stop during WAIT_PROC: sample still delivered
        clear_mon();
        adc_dly = 5; proc_dly = 4; stall_cfg = 0; adc_next = 16'h4321;
        period_in = 16'd20; burst_in = '0;
        pulse_start();
        for (int n = 0; n < 50 && n_vin == 0; n++) @(negedge clk);
        pulse_stop();
        wait_done("stop_wait_proc", 200);
        chk("stop.sample_cnt", int'(sample_cnt), 1);
        repeat (50) @(negedge clk);
        chk("stop.convst_count", n_conv, 1);
        chk("stop.done_count", n_done, 1);
        chk("stop.busy", int'(busy), 0);

        // Asynchronous reset in WAIT_ADC, then restart
        clear_mon();
        adc_dly = 0; period_in = 16'd20; burst_in = '0;
        pulse_start();
        repeat (3) @(negedge clk);
        chk("areset.busy_before", int'(busy), 1);
        @(posedge clk); #2 rst = 1'b0; #1;
        chk("areset.ctrl_outputs",
            int'({busy, done, adc_convst, valid_in, res_valid, overrun, timeout_err}), 0);
        chk("areset.sample_cnt", int'(sample_cnt), 0);
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("areset.no_done", n_done, 0);
        adc_dly = 2; proc_dly = 2; burst_in = 10'd1; adc_next = 16'h0A0A;
        pulse_start();
        chk("areset.convst_after_start", int'(adc_convst), 1);
        wait_done("areset_run", 200);
        chk("areset.sample_cnt_after", int'(sample_cnt), 1);

        // start together with stop: stays idle
        clear_mon();
        @(negedge clk); start = 1'b1; stop = 1'b1;
        @(negedge clk); start = 1'b0; stop = 1'b0;
        repeat (10) @(negedge clk);
        chk("startstop.convst_count", n_conv, 0);
        chk("startstop.busy", int'(busy), 0);

        // start while busy: ignored, burst length and period not relatched
        clear_mon();
        adc_dly = 3; proc_dly = 2; period_in = 16'd20; burst_in = 10'd2;
        pulse_start();
        repeat (5) @(negedge clk);
        burst_in = 10'd5; period_in = 16'd3;
        pulse_start();
        wait_done("busy_start", 300);
        repeat (3) @(negedge clk);
        chk("busystart.convst_count", n_conv, 2);
        chk("busystart.sample_cnt", int'(sample_cnt), 2);
        if (conv_cyc.size() >= 2)
            chk("busystart.convst_spacing", conv_cyc[1] - conv_cyc[0], 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        failures++;
        $display("FAIL watchdog actual=timeout required=completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
